debug_control: RTL and testbench

//   Front-panel controller for the single-cycle CPU debug board. Debounces the

---
 rtl/debug_control.sv | 148 ++++++++++++++
 tb/tb_debug_control.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/debug_control.sv
// Front-panel controller for the CPU debug board: synchronises and debounces the
// panel inputs, generates cpu_step (manual or auto-run), and drives the display counters.

module debug_control_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic sig_i,
  output logic press_o
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          stablePrev_q;
  logic          press_q, press_d;

  // A change is accepted only after DB_CYCLES consecutive samples disagree with the stable state
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sig_i == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sig_i;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign press_d = stable_q & ~stablePrev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stablePrev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stablePrev_q <= stable_q;
      press_q      <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

module debug_control #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int RUN_DIV   = 25_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_step,
  input  logic       btn_mode,
  input  logic       sw_run,
  output logic       cpu_step,
  output logic [7:0] disp_clock_count,
  output logic [1:0] disp_control
);

  localparam int DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(RUN_DIV - 1);

  logic stepS1_q, stepS2_q;
  logic modeS1_q, modeS2_q;
  logic runS1_q, runS2_q;

  logic stepPress, modePress;
  logic run;

  logic [DW-1:0] div_q, div_d;
  logic          cpuStep_q, cpuStep_d;
  logic [7:0]    count_q, count_d;
  logic [1:0]    ctl_q, ctl_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      stepS1_q <= 1'b0;
      stepS2_q <= 1'b0;
      modeS1_q <= 1'b0;
      modeS2_q <= 1'b0;
      runS1_q  <= 1'b0;
      runS2_q  <= 1'b0;
    end else begin
      stepS1_q <= btn_step;
      stepS2_q <= stepS1_q;
      modeS1_q <= btn_mode;
      modeS2_q <= modeS1_q;
      runS1_q  <= sw_run;
      runS2_q  <= runS1_q;
    end
  end

  debug_control_debounce #(.DB_CYCLES(DB_CYCLES)) uStepDb (
    .clock   (clock),
    .reset   (reset),
    .sig_i   (stepS2_q),
    .press_o (stepPress)
  );

  debug_control_debounce #(.DB_CYCLES(DB_CYCLES)) uModeDb (
    .clock   (clock),
    .reset   (reset),
    .sig_i   (modeS2_q),
    .press_o (modePress)
  );

  assign run = runS2_q;

  // With run low the divider is held at zero, so a terminal count in flight when run drops is lost
  always_comb begin
    div_d     = '0;
    cpuStep_d = stepPress;
    if (run) begin
      div_d     = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
      cpuStep_d = (div_q == DIV_MAX);
    end
    count_d = cpuStep_q ? count_q + 8'd1 : count_q;
    ctl_d   = modePress ? ctl_q + 2'd1 : ctl_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q     <= '0;
      cpuStep_q <= 1'b0;
      count_q   <= '0;
      ctl_q     <= '0;
    end else begin
      div_q     <= div_d;
      cpuStep_q <= cpuStep_d;
      count_q   <= count_d;
      ctl_q     <= ctl_d;
    end
  end

  assign cpu_step         = cpuStep_q;
  assign disp_clock_count = count_q;
  assign disp_control     = ctl_q;

endmodule

// File: tb/tb_debug_control.sv
// Directed bench for debug_control with short debounce and divider periods.

module tb_debug_control;

  localparam int DB_CYCLES = 4;
  localparam int RUN_DIV   = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       btn_step;
  logic       btn_mode;
  logic       sw_run;
  logic       cpu_step;
  logic [7:0] disp_clock_count;
  logic [1:0] disp_control;

  int errors = 0;
  int checks = 0;
  int pulseCount = 0;

  typedef struct {
    string name;
    bit    step;
    bit    mode;
    int    hold;
    int    gap;
    int    expPulses;
    int    expCount;
    int    expCtl;
  } vec_t;

  vec_t vecs[14];

  always #5 clock = ~clock;

  debug_control #(.DB_CYCLES(DB_CYCLES), .RUN_DIV(RUN_DIV)) dut (
    .clock            (clock),
    .reset            (reset),
    .btn_step         (btn_step),
    .btn_mode         (btn_mode),
    .sw_run           (sw_run),
    .cpu_step         (cpu_step),
    .disp_clock_count (disp_clock_count),
    .disp_control     (disp_control)
  );

  // Outputs are sampled 1 time unit after each rising edge; pulses are tallied here
  task automatic tick();
    @(posedge clock);
    #1;
    if (cpu_step === 1'b1) pulseCount++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit s, input bit m, input bit r, input int cycles);
    btn_step = s;
    btn_mode = m;
    sw_run   = r;
    repeat (cycles) tick();
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 3);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p0;
    int first;
    int guard;

    vecs[0]  = '{"step_hold20",   1'b1, 1'b0, 20, 20, 1, 1, 0};
    vecs[1]  = '{"mode_press1",   1'b0, 1'b1, 10, 10, 0, 1, 1};
    vecs[2]  = '{"mode_press2",   1'b0, 1'b1, 10, 10, 0, 1, 2};
    vecs[3]  = '{"mode_press3",   1'b0, 1'b1, 10, 10, 0, 1, 3};
    vecs[4]  = '{"mode_press4",   1'b0, 1'b1, 10, 10, 0, 1, 0};
    vecs[5]  = '{"mode_press5",   1'b0, 1'b1, 10, 10, 0, 1, 1};
    vecs[6]  = '{"step_and_mode", 1'b1, 1'b1, 10, 10, 1, 2, 2};
    vecs[7]  = '{"bounce1",       1'b1, 1'b0, 3,  1,  0, 2, 2};
    vecs[8]  = '{"bounce2",       1'b1, 1'b0, 3,  1,  0, 2, 2};
    vecs[9]  = '{"bounce3",       1'b1, 1'b0, 3,  1,  0, 2, 2};
    vecs[10] = '{"bounce4",       1'b1, 1'b0, 3,  1,  0, 2, 2};
    vecs[11] = '{"bounce5",       1'b1, 1'b0, 3,  10, 0, 2, 2};
    vecs[12] = '{"step_exact_db", 1'b1, 1'b0, 4,  10, 1, 3, 2};
    vecs[13] = '{"mode_short",    1'b0, 1'b1, 3,  10, 0, 3, 2};

    reset = 1'b1;
    btn_step = 1'b0;
    btn_mode = 1'b0;
    sw_run = 1'b0;

    // Reset with buttons held, then quiet period
    btn_step = 1'b1;
    btn_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("reset_outputs", {21'd0, cpu_step, disp_clock_count, disp_control}, 32'd0);
    end
    reset = 1'b0;
    p0 = pulseCount;
    applyStimulus(1'b0, 1'b0, 1'b0, 10);
    checkOutput("post_reset_quiet", pulseCount - p0, 0);

    // Manual step latency
    doReset();
    p0 = pulseCount;
    first = -1;
    btn_step = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cpu_step === 1'b1 && first < 0) first = i;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 20);
    checkOutput("step_latency", first, DB_CYCLES + 3);
    checkOutput("step_single_pulse", pulseCount - p0, 1);
    checkOutput("step_count", disp_clock_count, 1);

    // Table-driven button sequences
    doReset();
    for (int v = 0; v < 14; v++) begin
      p0 = pulseCount;
      applyStimulus(vecs[v].step, vecs[v].mode, 1'b0, vecs[v].hold);
      applyStimulus(1'b0, 1'b0, 1'b0, vecs[v].gap);
      checkOutput({vecs[v].name, "_pulses"}, pulseCount - p0, vecs[v].expPulses);
      checkOutput({vecs[v].name, "_count"}, disp_clock_count, vecs[v].expCount);
      checkOutput({vecs[v].name, "_ctl"}, disp_control, vecs[v].expCtl);
    end

    // Auto-run for 82 cycles with a step press in the middle
    doReset();
    p0 = pulseCount;
    first = -1;
    btn_step = 1'b0;
    sw_run = 1'b1;
    for (int i = 0; i < 82; i++) begin
      if (i == 20) btn_step = 1'b1;
      if (i == 40) btn_step = 1'b0;
      tick();
      if (cpu_step === 1'b1 && first < 0) first = i;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 20);
    checkOutput("run_first_pulse", first, RUN_DIV + 1);
    checkOutput("run_pulses", pulseCount - p0, 10);
    checkOutput("run_count", disp_clock_count, 10);

    // Count wrap after 256 auto-run pulses, then reset mid-divide
    doReset();
    p0 = pulseCount;
    sw_run = 1'b1;
    guard = 0;
    while (pulseCount - p0 < 255 && guard < 3000) begin
      tick();
      guard++;
    end
    tick();
    checkOutput("preload_count", disp_clock_count, 255);
    guard = 0;
    while (pulseCount - p0 < 256 && guard < 20) begin
      tick();
      guard++;
    end
    tick();
    checkOutput("wrap_count", disp_clock_count, 0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    tick();
    checkOutput("midrun_reset_step", cpu_step, 0);
    checkOutput("midrun_reset_count", disp_clock_count, 0);
    reset = 1'b0;
    first = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cpu_step === 1'b1 && first < 0) first = i;
    end
    checkOutput("restart_first_pulse", first, RUN_DIV + 1);
    sw_run = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
